// File: rtl/pc_gen.sv
// pc_gen: IF-stage program counter with a req/ack fetch handshake and jtag/trap/jump/hold priority.
// Optional PC_MISALIGN_EN: force-align redirect targets and flag misaligned ones on misalign_o.
module pc_gen #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter int                INST_BYTES = 4,
    parameter int                HOLD_W     = 3,
    parameter logic [HOLD_W-1:0] HOLD_NO    = 'd0,
    parameter logic [HOLD_W-1:0] HOLD_WAIT  = 'd1,
    parameter logic [HOLD_W-1:0] HOLD_FLUSH = 'd2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jtag_reset_i,
    input  logic              trap_flag_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic [HOLD_W-1:0] hold_flag_i,
    input  logic              fetch_ack_i,
    output logic              fetch_req_o,
    output logic [ADDR_W-1:0] pc_o,
`ifdef PC_MISALIGN_EN
    output logic              misalign_o,
`endif
    output logic              redirect_o
);
    localparam int LSB = $clog2(INST_BYTES);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt, w_target, w_target_al;
    logic              r_req, r_redirect, w_redirect;

    assign w_target = trap_flag_i ? trap_addr_i : jump_addr_i;

`ifdef PC_MISALIGN_EN
    logic r_misalign, w_misalign;
    assign w_misalign  = |w_target[LSB-1:0];
    assign w_target_al = {w_target[ADDR_W-1:LSB], {LSB{1'b0}}};
    assign misalign_o  = r_misalign;
`else
    assign w_target_al = w_target;
`endif

    // Priority chain: jtag > trap > jump > hold_wait > hold_flush > normal sequencing
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_redirect  = 1'b0;
        if (jtag_reset_i) begin
            w_state_nxt = BOOT;
            w_pc_nxt    = RESET_VEC;
        end else if (trap_flag_i || jump_flag_i) begin
            w_state_nxt = FETCH;
            w_pc_nxt    = w_target_al;
            w_redirect  = 1'b1;
        end else if (hold_flag_i == HOLD_WAIT) begin
            w_state_nxt = HOLD;
        end else if (hold_flag_i == HOLD_FLUSH) begin
            w_state_nxt = BOOT;
        end else if (r_state == BOOT) begin
            w_state_nxt = FETCH;
        end else if (r_state == FETCH && fetch_ack_i) begin
            w_pc_nxt = r_pc + ADDR_W'(INST_BYTES);
        end else if (r_state == HOLD && hold_flag_i == HOLD_NO) begin
            w_state_nxt = FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= BOOT;
            r_pc       <= RESET_VEC;
            r_req      <= 1'b0;
            r_redirect <= 1'b0;
`ifdef PC_MISALIGN_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req      <= (w_state_nxt == FETCH);
            r_redirect <= w_redirect;
`ifdef PC_MISALIGN_EN
            r_misalign <= w_redirect && w_misalign;
`endif
        end
    end

    assign fetch_req_o = r_req;
    assign pc_o        = r_pc;
    assign redirect_o  = r_redirect;
endmodule
